// File: rtl/score_keeper.sv
// Game score: edge-counted BCD score, session high score and play/over FSM; score updates 1 cycle after an eat edge.
// No backpressure: eat/game_over/restart are consumed whenever the current state accepts them, otherwise ignored.
module score_keeper #(
    parameter logic [7:0] MAX_SCORE = 8'h99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eat,
    input  logic       game_over,
    input  logic       restart,
    output logic [7:0] outscore,
    output logic [7:0] highscore,
    output logic       new_record,
    output logic       playing,
    output logic [1:0] level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        CMP  = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       eat_q;
    logic       eat_edge;
    logic       clear_score;
    logic       inc_score;
    logic       do_cmp;
    logic [7:0] score_inc;

    assign eat_edge = eat & ~eat_q;

    // Saturating packed-BCD increment of the current score.
    always_comb begin
        score_inc = outscore;
        if (outscore != MAX_SCORE) begin
            if (outscore[3:0] == 4'd9) begin
                score_inc[7:4] = outscore[7:4] + 4'd1;
                score_inc[3:0] = 4'd0;
            end else begin
                score_inc[3:0] = outscore[3:0] + 4'd1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        clear_score = 1'b0;
        inc_score   = 1'b0;
        do_cmp      = 1'b0;
        playing     = 1'b0;
        case (state)
            IDLE: begin
                if (restart) begin
                    state_next  = PLAY;
                    clear_score = 1'b1;
                end
            end
            PLAY: begin
                playing   = 1'b1;
                inc_score = eat_edge;
                if (game_over) begin
                    state_next = CMP;
                end
            end
            CMP: begin
                do_cmp     = 1'b1;
                state_next = OVER;
            end
            OVER: begin
                if (restart) begin
                    state_next  = PLAY;
                    clear_score = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eat_q      <= 1'b0;
            outscore   <= 8'h00;
            highscore  <= 8'h00;
            new_record <= 1'b0;
        end else begin
            eat_q <= eat;
            if (clear_score) begin
                outscore   <= 8'h00;
                new_record <= 1'b0;
            end else if (inc_score) begin
                outscore <= score_inc;
            end
            // Packed BCD orders the same as binary, so a plain compare suffices.
            if (do_cmp) begin
                if (outscore > highscore) begin
                    highscore  <= outscore;
                    new_record <= 1'b1;
                end else begin
                    new_record <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        if (outscore[7:4] >= 4'd3) begin
            level = 2'd3;
        end else begin
            level = outscore[5:4];
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: hand-computed score, high score, level and state sequences.
module tb_score_keeper;

    logic       clk;
    logic       reset;
    logic       eat;
    logic       game_over;
    logic       restart;
    logic [7:0] outscore;
    logic [7:0] highscore;
    logic       new_record;
    logic       playing;
    logic [1:0] level;

    int n_checks;
    int n_errors;

    score_keeper #(.MAX_SCORE(8'h99)) dut (
        .clk       (clk),
        .reset     (reset),
        .eat       (eat),
        .game_over (game_over),
        .restart   (restart),
        .outscore  (outscore),
        .highscore (highscore),
        .new_record(new_record),
        .playing   (playing),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eat_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            eat = 1'b1;
            step();
            eat = 1'b0;
            step();
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic pulse_game_over();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        eat       = 1'b0;
        game_over = 1'b0;
        restart   = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_score", outscore, 8'h00);
        check("rst_high", highscore, 8'h00);
        check("rst_newrec", 8'(new_record), 8'h00);
        check("rst_playing", 8'(playing), 8'h00);
        check("rst_level", 8'(level), 8'h00);

        // Three separate eats, each visible one cycle after its edge
        pulse_restart();
        check("start_playing", 8'(playing), 8'h01);
        check("start_score", outscore, 8'h00);
        eat = 1'b1; step(); check("eat1", outscore, 8'h01); eat = 1'b0; step();
        eat = 1'b1; step(); check("eat2", outscore, 8'h02); eat = 1'b0; step();
        eat = 1'b1; step(); check("eat3", outscore, 8'h03); eat = 1'b0; step();
        check("eat3_level", 8'(level), 8'h00);
        check("eat3_playing", 8'(playing), 8'h01);

        // Held eat counts once
        eat = 1'b1;
        repeat (10) step();
        eat = 1'b0;
        step();
        check("held_eat", outscore, 8'h04);

        eat_pulses(5);
        check("score09", outscore, 8'h09);
        eat_pulses(1);
        check("carry10", outscore, 8'h10);
        check("level1", 8'(level), 8'h01);
        eat_pulses(15);
        check("score25", outscore, 8'h25);
        check("level2", 8'(level), 8'h02);

        pulse_game_over();
        check("go_playing", 8'(playing), 8'h00);
        check("cmp_high_unchanged", highscore, 8'h00);
        step();
        check("high25", highscore, 8'h25);
        check("newrec25", 8'(new_record), 8'h01);

        pulse_game_over();
        check("over_go_playing", 8'(playing), 8'h00);
        check("over_go_high", highscore, 8'h25);

        pulse_restart();
        check("re_score", outscore, 8'h00);
        check("re_newrec", 8'(new_record), 8'h00);
        check("re_high", highscore, 8'h25);
        check("re_playing", 8'(playing), 8'h01);

        eat_pulses(3);
        pulse_restart();
        check("restart_in_play", outscore, 8'h03);
        check("restart_in_play_st", 8'(playing), 8'h01);
        eat_pulses(4);
        check("score07", outscore, 8'h07);
        pulse_game_over();
        step();
        check("low_high", highscore, 8'h25);
        check("low_newrec", 8'(new_record), 8'h00);

        // Eat held high across restart must not count
        eat = 1'b1;
        step();
        pulse_restart();
        step();
        step();
        check("held_restart", outscore, 8'h00);
        eat = 1'b0;
        step();

        eat_pulses(30);
        check("score30", outscore, 8'h30);
        check("level3_30", 8'(level), 8'h03);
        pulse_game_over();
        step();
        check("high30", highscore, 8'h30);
        check("newrec30", 8'(new_record), 8'h01);

        // Asynchronous reset mid-game
        pulse_restart();
        eat_pulses(14);
        check("score14", outscore, 8'h14);
        #3;
        reset = 1'b1;
        #1;
        check("arst_score", outscore, 8'h00);
        check("arst_high", highscore, 8'h00);
        check("arst_newrec", 8'(new_record), 8'h00);
        check("arst_playing", 8'(playing), 8'h00);
        check("arst_level", 8'(level), 8'h00);
        step();
        reset = 1'b0;
        eat_pulses(1);
        check("idle_eat", outscore, 8'h00);
        pulse_game_over();
        check("idle_go", 8'(playing), 8'h00);

        // Eat edge coincident with game_over
        pulse_restart();
        check("play_after_idle", 8'(playing), 8'h01);
        eat_pulses(19);
        check("score19", outscore, 8'h19);
        eat       = 1'b1;
        game_over = 1'b1;
        step();
        eat       = 1'b0;
        game_over = 1'b0;
        check("simul_score", outscore, 8'h20);
        check("simul_playing", 8'(playing), 8'h00);
        step();
        check("simul_high", highscore, 8'h20);
        check("simul_newrec", 8'(new_record), 8'h01);

        // Saturation
        pulse_restart();
        eat_pulses(99);
        check("sat99", outscore, 8'h99);
        check("sat_level", 8'(level), 8'h03);
        eat_pulses(2);
        check("sat_hold", outscore, 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
